drv_ad56x4_multi: RTL and testbench
===================================

// Module: drv_ad56x4_multi
// PURPOSE
//  Parametrised SPI driver for the AD56x3/AD56x4 DAC family (1-4 channels, 12-16 bit data).
//  On a ce strobe it latches one sample per enabled channel and shifts one 24-bit frame per channel.
//  Per channel: selectable signed/unsigned coding, channel mask, two update modes.
//  Sits between the sample-rate ce generator and the DAC pins; busy/done/overrun go to the control logic.
// PARAMETERS
//  NUM_CH         4        number of DAC channels, 1..4; channel i uses address i
//  DATA_WIDTH     16       sample width, 12..16; left-justified in the 16-bit data field
//  SIGNED_MASK    4'b0000  bit i=1: channel i input is two's complement (MSB inverted to offset binary)
//  SCLK_DIVIDER   2        clk cycles per sclk half-period, >=1
//  SYNC_DURATION  5        clk cycles dacSync stays high after each frame, >=1
//  UPDATE_MODE    "ALL"    "ALL": outputs update together on last frame; "EACH": every frame updates its channel
// PORTS
//  clk       in   1                  system clock
//  reset     in   1                  asynchronous, active-high reset
//  ce        in   1                  one-cycle start strobe; latches data and chMask
//  chMask    in   NUM_CH             bit i=1: send channel i in this transaction
//  data      in   NUM_CH*DATA_WIDTH  channel i sample at [i*DATA_WIDTH +: DATA_WIDTH]
//  dacSync   out  1                  DAC SYNC, active low for the duration of each frame
//  dacSclk   out  1                  DAC SCLK, idles high
//  dacDin    out  1                  DAC DIN, MSB first, stable around each falling sclk edge
//  busy      out  1                  transaction in progress
//  done      out  1                  one-cycle pulse when the transaction completes
//  overrun   out  1                  one-cycle pulse when ce arrives while busy, or chMask==0
// BEHAVIOUR
//  Reset values: dacSync=1, dacSclk=1, dacDin=0, busy=0, done=0, overrun=0, FSM=IDLE.
//  Reset mid-frame aborts immediately; the DAC discards the partial frame (SYNC rises early).
//  Start: ce=1 with busy=0 and chMask!=0 latches data and chMask, and sets busy=1 on the next edge.
//   - ce with busy=1: ignored; overrun=1 for 1 cycle; in-flight data stays unchanged.
//   - ce with chMask==0: no frames; overrun=1 for 1 cycle.
//   - ce in the same cycle as done (busy already 0): accepted.
//  Frame i = {2'b00, CMD[2:0], ADDR=i[2:0], code[15:0]}.
//   - code = {SIGNED_MASK[i]^d[MSB], d[MSB-1:0], (16-DATA_WIDTH) zeros}.
//  CMD selection:
//   - "EACH": 3'b011 (write and update channel n) on every frame.
//   - "ALL": 3'b000 (write input register) on every frame except the highest-index enabled
//     channel, which uses 3'b010 (write n, update all).
//  Frames go in ascending channel order, skipping masked-off channels.
//  FSM states and transitions:
//   - IDLE -> LOAD (1 cycle: build frame, dacSync falls, dacDin=bit23, sclk high).
//   - LOAD -> SHIFT: 24 sclk periods of 2*SCLK_DIVIDER clk each.
//     - sclk high for SCLK_DIVIDER clk, then low for SCLK_DIVIDER clk.
//     - dacDin advances at each rising sclk; the DAC samples on falling.
//   - SHIFT -> GAP: after the 24th low phase sclk returns high, dacSync=1 for SYNC_DURATION clk.
//   - GAP -> LOAD for the next enabled channel, or DONE.
//   - DONE: done=1, busy=0 for 1 cycle -> IDLE.
//  Timing:
//   - frame length Tf = 1 + 48*SCLK_DIVIDER + SYNC_DURATION clk.
//   - transaction = n_enabled*Tf + 1 clk.
//   - minimum ce period = NUM_CH*Tf + 1 clk.
//  Counters: bit counter 0..23 and divider counter 0..SCLK_DIVIDER-1 wrap to 0 at every frame start.
// STRUCTURE
//  Package drv_dac_pkg:
//   - FRAME_WIDTH=24.
//   - CMD_WRITE_INPUT=3'b000, CMD_WRITE_UPDATE_ALL=3'b010, CMD_WRITE_UPDATE_N=3'b011.
//   - typedef dac_frame_t.
//   - function build_frame(cmd, addr, sample, isSigned).
//  Sub-module dac_spi_serializer:
//   - 24-bit shifter plus sclk divider, with start/last/idle handshake.
//   - the top level keeps the channel-sequencing FSM and the latch registers.
// TESTING
//  1. NUM_CH=4, "ALL", mask 4'b1111, data ch0..3=16'h0000,16'h7FFF,16'h8000,16'hFFFF unsigned:
//     -> 4 frames h000000,h017FFF,h028000,h13FFFF; then done.
//  2. SIGNED_MASK=4'b0010, DATA_WIDTH=14, ch1=14'h2000:
//     -> ch1 frame code 16'h0000 (MSB inverted, 2 LSB zeros).
//  3. "EACH", mask 4'b0101, ch0=16'h1234, ch2=16'hABCD:
//     -> exactly 2 frames h181234, h1AABCD; busy high 2*Tf+1 clk.
//  4. ce again 10 clk after start:
//     -> overrun pulse; captured frames unchanged.
//     mask 0 with busy=0:
//     -> overrun pulse, busy stays 0, dacSync stays 1.
//  5. reset asserted at bit 10 of frame 1:
//     -> dacSync=1, dacSclk=1, busy=0 in the same cycle.
//     next ce:
//     -> a clean full transaction.
//  6. Back-to-back ce at exactly NUM_CH*Tf+1 clk period, 100 random vectors:
//     -> no overrun; decoded frames (sampled at falling sclk while SYNC low) match the model.

Source files
------------

// File: rtl/drv_dac_pkg.sv
// Shared types, constants and the frame builder for the AD56x3/AD56x4 driver.
package drv_dac_pkg;

    localparam int FRAME_WIDTH = 24;
    localparam int CODE_WIDTH  = 16;

    localparam logic [2:0] CMD_WRITE_INPUT      = 3'b000;
    localparam logic [2:0] CMD_WRITE_UPDATE_ALL = 3'b010;
    localparam logic [2:0] CMD_WRITE_UPDATE_N   = 3'b011;

    // One 24-bit shift-register word as the DAC expects it, MSB first.
    typedef struct packed {
        logic [1:0]            pad;
        logic [2:0]            cmd;
        logic [2:0]            addr;
        logic [CODE_WIDTH-1:0] code;
    } dac_frame_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP,
        ST_DONE
    } seq_state_t;

    // sample is already left-justified to 16 bits; a two's-complement input
    // becomes offset binary by flipping its sign bit.
    function automatic dac_frame_t build_frame(
        input logic [2:0]            cmd,
        input logic [2:0]            addr,
        input logic [CODE_WIDTH-1:0] sample,
        input logic                  isSigned
    );
        dac_frame_t f;
        f.pad  = 2'b00;
        f.cmd  = cmd;
        f.addr = addr;
        f.code = {sample[CODE_WIDTH-1] ^ isSigned, sample[CODE_WIDTH-2:0]};
        return f;
    endfunction

endpackage

// File: rtl/dac_spi_serializer.sv
// Shifts one 24-bit frame out MSB first with a divided SCLK.
// A start pulse loads the frame; the following cycle is the load cycle
// (SCLK high, DIN = bit 23), then 24 SCLK periods follow. last is high in
// the final clk of the 24th low phase; idle is high whenever no frame is on
// the wire and doubles as the SYNC level.
module dac_spi_serializer
    import drv_dac_pkg::*;
#(
    parameter int SCLK_DIVIDER = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [FRAME_WIDTH-1:0] frame,
    output logic                   sclk,
    output logic                   din,
    output logic                   last,
    output logic                   idle
);

    localparam int              DIV_W   = (SCLK_DIVIDER > 1) ? $clog2(SCLK_DIVIDER) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCLK_DIVIDER - 1);
    localparam logic [4:0]       BIT_MAX = 5'(FRAME_WIDTH - 1);

    logic [FRAME_WIDTH-1:0] shiftReg;
    logic [4:0]             bitCnt;
    logic [DIV_W-1:0]       divCnt;
    logic                   active;
    logic                   loadPhase;
    logic                   sclkReg;
    logic                   phaseEnd;

    assign phaseEnd = active && !loadPhase && (divCnt == DIV_MAX);
    assign last     = phaseEnd && !sclkReg && (bitCnt == BIT_MAX);
    assign sclk     = sclkReg;
    assign din      = active & shiftReg[FRAME_WIDTH-1];
    assign idle     = !active;

    // Frame shifter and SCLK divider: data advances on each rising SCLK.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            shiftReg  <= '0;
            bitCnt    <= '0;
            divCnt    <= '0;
            active    <= 1'b0;
            loadPhase <= 1'b0;
            sclkReg   <= 1'b1;
        end else if (start) begin
            shiftReg  <= frame;
            bitCnt    <= '0;
            divCnt    <= '0;
            active    <= 1'b1;
            loadPhase <= 1'b1;
            sclkReg   <= 1'b1;
        end else if (active) begin
            if (loadPhase) begin
                loadPhase <= 1'b0;
            end else if (phaseEnd) begin
                divCnt <= '0;
                if (sclkReg) begin
                    sclkReg <= 1'b0;
                end else begin
                    sclkReg <= 1'b1;
                    if (last) begin
                        active <= 1'b0;
                    end else begin
                        bitCnt   <= bitCnt + 5'd1;
                        shiftReg <= {shiftReg[FRAME_WIDTH-2:0], 1'b0};
                    end
                end
            end else begin
                divCnt <= divCnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/drv_ad56x4_multi.sv
// Multi-channel SPI driver for AD56x3/AD56x4 DACs. A ce strobe latches one
// sample per enabled channel; frames then go out in ascending channel order
// with a SYNC-high gap after each one.
module drv_ad56x4_multi
    import drv_dac_pkg::*;
#(
    parameter int         NUM_CH        = 4,
    parameter int         DATA_WIDTH    = 16,
    parameter logic [3:0] SIGNED_MASK   = 4'b0000,
    parameter int         SCLK_DIVIDER  = 2,
    parameter int         SYNC_DURATION = 5,
    parameter string      UPDATE_MODE   = "ALL"
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic [NUM_CH-1:0]            chMask,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data,
    output logic                         dacSync,
    output logic                         dacSclk,
    output logic                         dacDin,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun
);

    localparam bit               EACH_MODE = (UPDATE_MODE == "EACH");
    localparam int               GAP_W     = (SYNC_DURATION > 1) ? $clog2(SYNC_DURATION) : 1;
    localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(SYNC_DURATION - 1);

    seq_state_t state, nextState;

    logic [NUM_CH-1:0]            maskReg;
    logic [NUM_CH*DATA_WIDTH-1:0] dataReg;
    logic [2:0]                   chReg;
    logic                         lastReg;
    logic [GAP_W-1:0]             gapCnt;
    logic                         overrunReg;

    logic                         idleState;
    logic                         accept;
    logic                         gapEnd;
    logic                         startFrame;

    logic [NUM_CH-1:0]            srcMask;
    logic [NUM_CH*DATA_WIDTH-1:0] srcData;
    int                           searchFrom;
    logic                         found;
    logic                         moreAfter;
    logic [2:0]                   pickCh;
    logic [DATA_WIDTH-1:0]        pickSample;
    logic                         pickSigned;
    logic [2:0]                   cmd;
    logic [CODE_WIDTH-1:0]        sample16;
    dac_frame_t                   frameWord;

    logic                         serLast;
    logic                         serIdle;

    // The DONE cycle already counts as not busy, so ce there starts a new transaction.
    assign idleState  = (state == ST_IDLE) || (state == ST_DONE);
    assign accept     = idleState && ce && (chMask != '0);
    assign gapEnd     = (state == ST_GAP) && (gapCnt == GAP_MAX);
    assign startFrame = accept || (gapEnd && !lastReg);

    assign busy    = !idleState;
    assign done    = (state == ST_DONE);
    assign overrun = overrunReg;
    assign dacSync = serIdle;

    // Pick the next enabled channel and build its frame; the first frame of a
    // transaction comes straight from the ports because the latch happens on the same edge.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        srcMask    = maskReg;
        srcData    = dataReg;
        searchFrom = int'(chReg) + 1;
        found      = 1'b0;
        moreAfter  = 1'b0;
        pickCh     = '0;
        pickSample = '0;
        pickSigned = 1'b0;
        if (accept) begin
            srcMask    = chMask;
            srcData    = data;
            searchFrom = 0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (srcMask[i] && (i >= searchFrom)) begin
                if (found) begin
                    moreAfter = 1'b1;
                end else begin
                    found      = 1'b1;
                    pickCh     = 3'(i);
                    pickSample = srcData[i*DATA_WIDTH +: DATA_WIDTH];
                    pickSigned = SIGNED_MASK[i];
                end
            end
        end
        if (EACH_MODE) begin
            cmd = CMD_WRITE_UPDATE_N;
        end else if (moreAfter) begin
            cmd = CMD_WRITE_INPUT;
        end else begin
            cmd = CMD_WRITE_UPDATE_ALL;
        end
        sample16  = CODE_WIDTH'(pickSample) << (CODE_WIDTH - DATA_WIDTH);
        frameWord = build_frame(cmd, pickCh, sample16, pickSigned);
    end

    // Channel-sequencing next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:  if (accept) nextState = ST_LOAD;
            ST_LOAD:  nextState = ST_SHIFT;
            ST_SHIFT: if (serLast) nextState = ST_GAP;
            ST_GAP:   if (gapEnd) nextState = lastReg ? ST_DONE : ST_LOAD;
            ST_DONE:  nextState = accept ? ST_LOAD : ST_IDLE;
            default:  nextState = ST_IDLE;
        endcase
    end

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Transaction latches, current channel, SYNC gap timer and overrun pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            maskReg    <= '0;
            dataReg    <= '0;
            chReg      <= '0;
            lastReg    <= 1'b0;
            gapCnt     <= '0;
            overrunReg <= 1'b0;
        end else begin
            if (accept) begin
                maskReg <= chMask;
                dataReg <= data;
            end
            if (startFrame) begin
                chReg   <= pickCh;
                lastReg <= !moreAfter;
            end
            gapCnt     <= (state == ST_GAP) ? gapCnt + GAP_W'(1) : '0;
            overrunReg <= ce && (!idleState || (chMask == '0));
        end
    end

    dac_spi_serializer #(
        .SCLK_DIVIDER(SCLK_DIVIDER)
    ) serializer (
        .clk  (clk),
        .reset(reset),
        .start(startFrame),
        .frame(frameWord),
        .sclk (dacSclk),
        .din  (dacDin),
        .last (serLast),
        .idle (serIdle)
    );

endmodule

// File: tb/tb_drv_ad56x4_multi.sv
// Bench for drv_ad56x4_multi: three instances (ALL/16-bit, ALL/14-bit signed
// ch1, EACH/16-bit) share clock and reset; frames are decoded from the pins.
module tb_drv_ad56x4_multi;

    localparam int TF     = 1 + 48 * 2 + 5;
    localparam int PERIOD = 4 * TF + 1;

    logic        clk;
    logic        reset;
    logic        ceW   [3];
    logic [3:0]  maskW [3];
    logic [63:0] dataW [3];
    logic        syncW [3];
    logic        sclkW [3];
    logic        dinW  [3];
    logic        busyW [3];
    logic        doneW [3];
    logic        ovW   [3];

    int nChecks = 0;
    int nPass   = 0;
    int ovCnt0  = 0;
    logic [23:0] expQ [$];

    drv_ad56x4_multi #(.NUM_CH(4), .DATA_WIDTH(16), .SIGNED_MASK(4'b0000),
        .SCLK_DIVIDER(2), .SYNC_DURATION(5), .UPDATE_MODE("ALL")) dutA (
        .clk(clk), .reset(reset), .ce(ceW[0]), .chMask(maskW[0]), .data(dataW[0]),
        .dacSync(syncW[0]), .dacSclk(sclkW[0]), .dacDin(dinW[0]),
        .busy(busyW[0]), .done(doneW[0]), .overrun(ovW[0]));

    drv_ad56x4_multi #(.NUM_CH(4), .DATA_WIDTH(14), .SIGNED_MASK(4'b0010),
        .SCLK_DIVIDER(2), .SYNC_DURATION(5), .UPDATE_MODE("ALL")) dutB (
        .clk(clk), .reset(reset), .ce(ceW[1]), .chMask(maskW[1]), .data(dataW[1][55:0]),
        .dacSync(syncW[1]), .dacSclk(sclkW[1]), .dacDin(dinW[1]),
        .busy(busyW[1]), .done(doneW[1]), .overrun(ovW[1]));

    drv_ad56x4_multi #(.NUM_CH(4), .DATA_WIDTH(16), .SIGNED_MASK(4'b0000),
        .SCLK_DIVIDER(2), .SYNC_DURATION(5), .UPDATE_MODE("EACH")) dutC (
        .clk(clk), .reset(reset), .ce(ceW[2]), .chMask(maskW[2]), .data(dataW[2]),
        .dacSync(syncW[2]), .dacSclk(sclkW[2]), .dacDin(dinW[2]),
        .busy(busyW[2]), .done(doneW[2]), .overrun(ovW[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pin-level frame decoder: one bit per falling SCLK while SYNC is low;
    // a frame counts only if SYNC rises after exactly 24 bits.
    for (genvar g = 0; g < 3; g++) begin : gDec
        logic [23:0] sh = '0;
        int          bc = 0;
        int          capCnt = 0;
        logic [23:0] capBuf [1024];
        always @(negedge sclkW[g] or posedge syncW[g]) begin
            if (syncW[g] === 1'b1) begin
                if (bc == 24) begin
                    capBuf[capCnt % 1024] = sh;
                    capCnt++;
                end
                bc = 0;
            end else begin
                sh = {sh[22:0], dinW[g]};
                bc++;
            end
        end
    end

    always @(negedge clk) if (ovW[0] === 1'b1) ovCnt0++;

    function automatic int getCnt(input int d);
        case (d)
            0:       return gDec[0].capCnt;
            1:       return gDec[1].capCnt;
            default: return gDec[2].capCnt;
        endcase
    endfunction

    function automatic logic [23:0] getFrame(input int d, input int idx);
        case (d)
            0:       return gDec[0].capBuf[idx % 1024];
            1:       return gDec[1].capBuf[idx % 1024];
            default: return gDec[2].capBuf[idx % 1024];
        endcase
    endfunction

    // Reference: frames each instance must emit for one ce, straight from the frame format.
    function automatic int modelPush(input int d, input logic [3:0] mask, input logic [63:0] dat);
        int         dw    = (d == 1) ? 14 : 16;
        logic [3:0] smask = (d == 1) ? 4'b0010 : 4'b0000;
        bit         each  = (d == 2);
        int         top   = -1;
        int         n     = 0;
        for (int ch = 0; ch < 4; ch++) if (mask[ch]) top = ch;
        for (int ch = 0; ch < 4; ch++) begin
            if (mask[ch]) begin
                logic [15:0] raw  = 16'((dat >> (ch * dw)) & ((64'd1 << dw) - 64'd1));
                logic [15:0] code = (raw << (16 - dw)) ^ (smask[ch] ? 16'h8000 : 16'h0000);
                int          cmd  = each ? 3 : ((ch == top) ? 2 : 0);
                expQ.push_back(24'((cmd << 19) | (ch << 16) | int'(code)));
                n++;
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nChecks++;
        if (act === req) nPass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse ce, then count cycles with busy or done up to and including done.
    task automatic runTxn(input int d, input logic [3:0] m, input logic [63:0] dat,
                          output int cycles, output bit timedOut);
        ceW[d] = 1'b1; maskW[d] = m; dataW[d] = dat;
        step();
        ceW[d] = 1'b0;
        cycles = 0; timedOut = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (busyW[d] || doneW[d]) cycles++;
            if (doneW[d]) begin
                timedOut = 1'b0;
                break;
            end
            step();
        end
    endtask

    task automatic compareQ(input int d, input int c0, input string tag);
        int got = getCnt(d) - c0;
        check({tag, "_count"}, 64'(got), 64'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < got; i++)
            check({tag, "_frame"}, 64'(getFrame(d, c0 + i)), 64'(expQ[i]));
    endtask

    typedef struct {
        int               dut;
        logic [3:0]       mask;
        logic [63:0]      data;
        int               nExp;
        logic [3:0][23:0] exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int  cycles, c0, n;
        bit  tmo;
        logic [3:0]  m;
        logic [63:0] dv;

        vecs[0] = '{0, 4'b1111, 64'hFFFF_8000_7FFF_0000, 4, {24'h13FFFF, 24'h028000, 24'h017FFF, 24'h000000}};
        vecs[1] = '{1, 4'b0010, 64'h0000_0000_0800_0000, 1, {24'h0, 24'h0, 24'h0, 24'h110000}};
        vecs[2] = '{2, 4'b0101, 64'h0000_ABCD_0000_1234, 2, {24'h0, 24'h0, 24'h1AABCD, 24'h181234}};
        vecs[3] = '{1, 4'b1111, 64'h0055_5400_1FFF_FFFF, 4, {24'h135554, 24'h020004, 24'h017FFC, 24'h00FFFC}};
        vecs[4] = '{0, 4'b1000, 64'hBEEF_0000_0000_0000, 1, {24'h0, 24'h0, 24'h0, 24'h13BEEF}};
        vecs[5] = '{2, 4'b0110, 64'h0000_5A5A_0F0F_0000, 2, {24'h0, 24'h0, 24'h1A5A5A, 24'h190F0F}};
        vecs[6] = '{0, 4'b1010, 64'h0002_0000_8001_0000, 2, {24'h0, 24'h0, 24'h130002, 24'h018001}};

        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            ceW[d] = 1'b0; maskW[d] = '0; dataW[d] = '0;
        end
        repeat (3) step();
        check("rst_sync", 64'(syncW[0]), 64'd1);
        check("rst_sclk", 64'(sclkW[0]), 64'd1);
        check("rst_din",  64'(dinW[0]),  64'd0);
        check("rst_busy", 64'(busyW[0]), 64'd0);
        check("rst_done", 64'(doneW[0]), 64'd0);
        check("rst_ovr",  64'(ovW[0]),   64'd0);
        #2 reset = 1'b0;
        repeat (2) step();

        // Directed vectors with hand-derived frames.
        for (int v = 0; v < 7; v++) begin
            c0 = getCnt(vecs[v].dut);
            runTxn(vecs[v].dut, vecs[v].mask, vecs[v].data, cycles, tmo);
            check("vec_done_seen", 64'(tmo), 64'd0);
            check("vec_busy_len", 64'(cycles), 64'(vecs[v].nExp * TF + 1));
            check("vec_count", 64'(getCnt(vecs[v].dut) - c0), 64'(vecs[v].nExp));
            for (int i = 0; i < vecs[v].nExp; i++)
                check("vec_frame", 64'(getFrame(vecs[v].dut, c0 + i)), 64'(vecs[v].exp[i]));
            step();
            check("vec_done_pulse", 64'(doneW[vecs[v].dut]), 64'd0);
        end

        // ce while busy: overrun pulse, in-flight data unchanged.
        expQ.delete();
        c0 = getCnt(0);
        n  = modelPush(0, 4'b1111, 64'h1111_2222_3333_4444);
        ceW[0] = 1'b1; maskW[0] = 4'b1111; dataW[0] = 64'h1111_2222_3333_4444;
        step();
        ceW[0] = 1'b0;
        repeat (9) step();
        ceW[0] = 1'b1; maskW[0] = 4'b0001; dataW[0] = 64'hAAAA_BBBB_CCCC_DDDD;
        step();
        ceW[0] = 1'b0;
        check("ovr_pulse", 64'(ovW[0]), 64'd1);
        check("ovr_still_busy", 64'(busyW[0]), 64'd1);
        step();
        check("ovr_one_cycle", 64'(ovW[0]), 64'd0);
        tmo = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (doneW[0]) begin tmo = 1'b0; break; end
            step();
        end
        check("ovr_done_seen", 64'(tmo), 64'd0);
        compareQ(0, c0, "ovr");

        // ce with an empty mask while idle.
        repeat (3) step();
        c0 = getCnt(0);
        ceW[0] = 1'b1; maskW[0] = 4'b0000;
        step();
        ceW[0] = 1'b0;
        check("mask0_ovr", 64'(ovW[0]), 64'd1);
        check("mask0_busy", 64'(busyW[0]), 64'd0);
        check("mask0_sync", 64'(syncW[0]), 64'd1);
        step();
        check("mask0_ovr_end", 64'(ovW[0]), 64'd0);
        repeat (20) step();
        check("mask0_still_idle", 64'({busyW[0], syncW[0]}), 64'b01);
        check("mask0_no_frames", 64'(getCnt(0) - c0), 64'd0);

        // Reset in the middle of the second frame.
        expQ.delete();
        c0 = getCnt(0);
        n  = modelPush(0, 4'b1111, 64'hDEAD_BEEF_CAFE_F00D);
        ceW[0] = 1'b1; maskW[0] = 4'b1111; dataW[0] = 64'hDEAD_BEEF_CAFE_F00D;
        step();
        ceW[0] = 1'b0;
        repeat (TF + 42) step();
        check("abort_in_frame", 64'({syncW[0], busyW[0]}), 64'b01);
        #2 reset = 1'b1;
        #1;
        check("abort_sync", 64'(syncW[0]), 64'd1);
        check("abort_sclk", 64'(sclkW[0]), 64'd1);
        check("abort_busy", 64'(busyW[0]), 64'd0);
        check("abort_partial_dropped", 64'(getCnt(0) - c0), 64'd1);
        if (getCnt(0) - c0 >= 1)
            check("abort_frame0", 64'(getFrame(0, c0)), 64'(expQ[0]));
        repeat (2) step();
        #2 reset = 1'b0;
        repeat (2) step();
        expQ.delete();
        c0 = getCnt(0);
        n  = modelPush(0, 4'b1111, 64'h0123_4567_89AB_CDEF);
        runTxn(0, 4'b1111, 64'h0123_4567_89AB_CDEF, cycles, tmo);
        check("after_abort_done", 64'(tmo), 64'd0);
        check("after_abort_len", 64'(cycles), 64'(n * TF + 1));
        compareQ(0, c0, "after_abort");

        // Back-to-back random transactions at the minimum ce period.
        repeat (3) step();
        expQ.delete();
        c0 = getCnt(0);
        n  = ovCnt0;
        for (int v = 0; v < 100; v++) begin
            m  = 4'($urandom_range(1, 15));
            dv = {$urandom, $urandom};
            void'(modelPush(0, m, dv));
            ceW[0] = 1'b1; maskW[0] = m; dataW[0] = dv;
            step();
            ceW[0] = 1'b0;
            repeat (PERIOD - 1) step();
        end
        tmo = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (!busyW[0]) begin tmo = 1'b0; break; end
            step();
        end
        check("rand_finished", 64'(tmo), 64'd0);
        check("rand_no_overrun", 64'(ovCnt0 - n), 64'd0);
        compareQ(0, c0, "rand");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
